// File: rtl/ucsbece154a_memarb.sv
// Two-port memory arbiter: IDLE -> ACC (one memory cycle) -> RSP (ack), 32-bit address/data.
// Define MEMARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module ucsbece154a_memarb (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req0_i,
    input  logic        req1_i,
    input  logic        we0_i,
    input  logic        we1_i,
    input  logic [31:0] a0_i,
    input  logic [31:0] a1_i,
    input  logic [31:0] wd0_i,
    input  logic [31:0] wd1_i,
    output logic        gnt0_o,
    output logic        gnt1_o,
    output logic        ack0_o,
    output logic        ack1_o,
    output logic [31:0] rd_o,
    output logic        err_o,
    output logic        mem_we_o,
    output logic [31:0] mem_a_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i
);

    typedef enum logic [1:0] {IDLE, ACC, RSP} state_t;

    state_t      state_reg;
    logic        owner_reg;
    logic        last_owner_reg;
    logic        we_reg;
    logic        misalign_reg;
    logic [31:0] a_reg;
    logic [31:0] wd_reg;
    logic [31:0] rd_reg;
    logic        err_reg;
    logic        gnt0_reg;
    logic        gnt1_reg;
    logic        ack0_reg;
    logic        ack1_reg;

    logic        pick1;
    logic        sel_we;
    logic [31:0] sel_a;
    logic [31:0] sel_wd;

`ifdef MEMARB_ROUND_ROBIN_EN
    // On a tie, the port that did not own the previous transaction wins.
    assign pick1 = req1_i & (~req0_i | ~last_owner_reg);
`else
    // last_owner_reg is pinned at 1 here, so port 0 always wins a tie.
    assign pick1 = req1_i & ~(req0_i & last_owner_reg);
`endif

    assign sel_we = pick1 ? we1_i : we0_i;
    assign sel_a  = pick1 ? a1_i  : a0_i;
    assign sel_wd = pick1 ? wd1_i : wd0_i;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            owner_reg      <= 1'b0;
            last_owner_reg <= 1'b1;
            we_reg         <= 1'b0;
            misalign_reg   <= 1'b0;
            a_reg          <= 32'h0000_0000;
            wd_reg         <= 32'h0000_0000;
            rd_reg         <= 32'h0000_0000;
            err_reg        <= 1'b0;
            gnt0_reg       <= 1'b0;
            gnt1_reg       <= 1'b0;
            ack0_reg       <= 1'b0;
            ack1_reg       <= 1'b0;
        end else begin
            gnt0_reg <= 1'b0;
            gnt1_reg <= 1'b0;
            ack0_reg <= 1'b0;
            ack1_reg <= 1'b0;
            case (state_reg)
                IDLE, RSP: begin
                    if (req0_i || req1_i) begin
                        owner_reg    <= pick1;
                        we_reg       <= sel_we;
                        a_reg        <= {sel_a[31:2], 2'b00};
                        wd_reg       <= sel_wd;
                        misalign_reg <= |sel_a[1:0];
                        gnt0_reg     <= ~pick1;
                        gnt1_reg     <= pick1;
`ifdef MEMARB_ROUND_ROBIN_EN
                        last_owner_reg <= pick1;
`endif
                        state_reg    <= ACC;
                    end else begin
                        state_reg    <= IDLE;
                    end
                end
                ACC: begin
                    if (!we_reg) begin
                        rd_reg <= mem_rd_i;
                    end
                    err_reg   <= misalign_reg;
                    ack0_reg  <= ~owner_reg;
                    ack1_reg  <= owner_reg;
                    state_reg <= RSP;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Derived from the state register so an asynchronous reset kills the write at once.
    assign mem_we_o = (state_reg == ACC) && we_reg;
    assign mem_a_o  = a_reg;
    assign mem_wd_o = wd_reg;
    assign rd_o     = rd_reg;
    assign err_o    = err_reg;
    assign gnt0_o   = gnt0_reg;
    assign gnt1_o   = gnt1_reg;
    assign ack0_o   = ack0_reg;
    assign ack1_o   = ack1_reg;

endmodule

// File: tb/tb_ucsbece154a_memarb.sv
// Testbench for ucsbece154a_memarb: directed scenarios plus randomized transactions
// checked against a transaction-level model (winner choice, memory image, rd/err).
module tb_ucsbece154a_memarb;

`ifdef MEMARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req0_i, req1_i, we0_i, we1_i;
    logic [31:0] a0_i, a1_i, wd0_i, wd1_i;
    logic        gnt0_o, gnt1_o, ack0_o, ack1_o;
    logic [31:0] rd_o;
    logic        err_o;
    logic        mem_we_o;
    logic [31:0] mem_a_o, mem_wd_o, mem_rd_i;

    int vectors = 0;
    int miscompares = 0;

    // Environment memory (seen by the DUT) and the model's own image of it.
    logic [31:0] mem [0:63];
    logic [31:0] ref_mem [0:63];
    logic        fill;
    int          last_model;
    logic [31:0] rd_model;
    logic        err_model;

    always #5 clk = ~clk;

    assign mem_rd_i = mem[mem_a_o[7:2]];

    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h2008_0004 + i;
        end else if (mem_we_o) begin
            mem[mem_a_o[7:2]] <= mem_wd_o;
        end
    end

    ucsbece154a_memarb dut (
        .clk(clk), .reset_n(reset_n),
        .req0_i(req0_i), .req1_i(req1_i), .we0_i(we0_i), .we1_i(we1_i),
        .a0_i(a0_i), .a1_i(a1_i), .wd0_i(wd0_i), .wd1_i(wd1_i),
        .gnt0_o(gnt0_o), .gnt1_o(gnt1_o), .ack0_o(ack0_o), .ack1_o(ack1_o),
        .rd_o(rd_o), .err_o(err_o), .mem_we_o(mem_we_o),
        .mem_a_o(mem_a_o), .mem_wd_o(mem_wd_o), .mem_rd_i(mem_rd_i)
    );

    function automatic int winner(input bit p0, input bit p1);
        if (p0 && p1) return RR ? ((last_model == 1) ? 0 : 1) : 0;
        return p1 ? 1 : 0;
    endfunction

    // Issue one request per selected port; each port drops req once granted.
    task automatic run_pair(input bit r0, input bit r1, input bit w0, input bit w1,
                            input logic [31:0] x0, input logic [31:0] x1,
                            input logic [31:0] d0, input logic [31:0] d1);
        bit p0 = r0;
        bit p1 = r1;
        int w;
        bit wew;
        logic [31:0] a, d;
        @(negedge clk);
        req0_i = r0; we0_i = w0; a0_i = x0; wd0_i = d0;
        req1_i = r1; we1_i = w1; a1_i = x1; wd1_i = d1;
        while (p0 || p1) begin
            w   = winner(p0, p1);
            wew = (w == 1) ? w1 : w0;
            a   = (w == 1) ? x1 : x0;
            d   = (w == 1) ? d1 : d0;
            @(negedge clk);
            vectors++; if (gnt0_o !== (w == 0)) begin miscompares++; $display("FAIL acc_gnt0: got %b want %b", gnt0_o, (w == 0)); end
            vectors++; if (gnt1_o !== (w == 1)) begin miscompares++; $display("FAIL acc_gnt1: got %b want %b", gnt1_o, (w == 1)); end
            vectors++; if (mem_we_o !== wew) begin miscompares++; $display("FAIL acc_we: got %b want %b", mem_we_o, wew); end
            vectors++; if (mem_a_o !== {a[31:2], 2'b00}) begin miscompares++; $display("FAIL acc_addr: got %h want %h", mem_a_o, {a[31:2], 2'b00}); end
            if (wew) begin
                vectors++; if (mem_wd_o !== d) begin miscompares++; $display("FAIL acc_wd: got %h want %h", mem_wd_o, d); end
            end
            if (w == 0) begin req0_i = 1'b0; p0 = 1'b0; end
            else begin req1_i = 1'b0; p1 = 1'b0; end
            if (RR) last_model = w;
            if (wew) ref_mem[a[7:2]] = d;
            else rd_model = ref_mem[a[7:2]];
            err_model = |a[1:0];
            @(negedge clk);
            vectors++; if ({ack1_o, ack0_o} !== ((w == 1) ? 2'b10 : 2'b01)) begin miscompares++; $display("FAIL rsp_ack: got %b%b want port %0d", ack1_o, ack0_o, w); end
            vectors++; if ({gnt1_o, gnt0_o, mem_we_o} !== 3'b000) begin miscompares++; $display("FAIL rsp_quiet: got gnt=%b%b we=%b want 0", gnt1_o, gnt0_o, mem_we_o); end
            vectors++; if (rd_o !== rd_model) begin miscompares++; $display("FAIL rsp_rd: got %h want %h", rd_o, rd_model); end
            vectors++; if (err_o !== err_model) begin miscompares++; $display("FAIL rsp_err: got %b want %b", err_o, err_model); end
            $display("txn port=%0d we=%0d a=%h wd=%h rd=%h err=%0d", w, wew, a, d, rd_o, err_o);
        end
        @(negedge clk);
        vectors++; if ({gnt1_o, gnt0_o, ack1_o, ack0_o} !== 4'b0000) begin miscompares++; $display("FAIL idle_quiet: got %b%b%b%b want 0000", gnt1_o, gnt0_o, ack1_o, ack0_o); end
    endtask

    task automatic test_reset();
        vectors++; if ({gnt0_o, gnt1_o, ack0_o, ack1_o, err_o, mem_we_o} !== 6'b0) begin miscompares++; $display("FAIL reset_ctl: got %b want 000000", {gnt0_o, gnt1_o, ack0_o, ack1_o, err_o, mem_we_o}); end
        vectors++; if (rd_o !== 32'h0) begin miscompares++; $display("FAIL reset_rd: got %h want 0", rd_o); end
        vectors++; if (mem_a_o !== 32'h0) begin miscompares++; $display("FAIL reset_addr: got %h want 0", mem_a_o); end
        vectors++; if (mem_wd_o !== 32'h0) begin miscompares++; $display("FAIL reset_wd: got %h want 0", mem_wd_o); end
        $display("txn reset rd=%h addr=%h", rd_o, mem_a_o);
    endtask

    task automatic test_read();
        run_pair(1'b1, 1'b0, 1'b0, 1'b0, 32'h0040_0004, 32'h0, 32'h0, 32'h0);
        vectors++; if (rd_o !== 32'h2008_0005) begin miscompares++; $display("FAIL read_value: got %h want 20080005", rd_o); end
    endtask

    task automatic test_write();
        int we_cycles = 0;
        fork
            run_pair(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h1000_0008, 32'h0, 32'hDEAD_BEEF);
            repeat (5) begin @(posedge clk); #1; if (mem_we_o) we_cycles++; end
        join
        vectors++; if (we_cycles != 1) begin miscompares++; $display("FAIL write_cycles: got %0d want 1", we_cycles); end
    endtask

    task automatic test_misalign();
        run_pair(1'b1, 1'b0, 1'b0, 1'b0, 32'h1000_0006, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic test_continuous();
        int exp;
        logic [31:0] x0 = 32'h0000_0010;
        logic [31:0] x1 = 32'h0000_0024;
        @(negedge clk);
        req0_i = 1'b1; we0_i = 1'b0; a0_i = x0;
        req1_i = 1'b1; we1_i = 1'b0; a1_i = x1;
        for (int k = 0; k < 4; k++) begin
            exp = winner(1'b1, 1'b1);
            @(negedge clk);
            vectors++; if ({gnt1_o, gnt0_o} !== ((exp == 1) ? 2'b10 : 2'b01)) begin miscompares++; $display("FAIL cont_gnt%0d: got %b%b want port %0d", k, gnt1_o, gnt0_o, exp); end
            if (RR) last_model = exp;
            rd_model = ref_mem[(exp == 1) ? x1[7:2] : x0[7:2]];
            err_model = 1'b0;
            @(negedge clk);
            vectors++; if ({ack1_o, ack0_o} !== ((exp == 1) ? 2'b10 : 2'b01)) begin miscompares++; $display("FAIL cont_ack%0d: got %b%b want port %0d", k, ack1_o, ack0_o, exp); end
            vectors++; if (rd_o !== rd_model) begin miscompares++; $display("FAIL cont_rd%0d: got %h want %h", k, rd_o, rd_model); end
            $display("txn continuous k=%0d port=%0d rd=%h", k, exp, rd_o);
            if (k == 3) begin req0_i = 1'b0; req1_i = 1'b0; end
        end
        @(negedge clk);
        vectors++; if ({gnt1_o, gnt0_o} !== 2'b00) begin miscompares++; $display("FAIL cont_idle: got %b%b want 00", gnt1_o, gnt0_o); end
    endtask

    task automatic test_back_to_back();
        time t1;
        logic [31:0] x = 32'h0000_0030;
        logic [31:0] y = 32'h0000_0034;
        @(negedge clk);
        req0_i = 1'b1; we0_i = 1'b0; a0_i = x;
        @(negedge clk);
        vectors++; if (gnt0_o !== 1'b1) begin miscompares++; $display("FAIL b2b_gnt_a: got %b want 1", gnt0_o); end
        a0_i = y;
        if (RR) last_model = 0;
        rd_model = ref_mem[x[7:2]];
        err_model = 1'b0;
        @(negedge clk);
        vectors++; if (ack0_o !== 1'b1 || rd_o !== rd_model) begin miscompares++; $display("FAIL b2b_ack_a: got ack=%b rd=%h want 1 %h", ack0_o, rd_o, rd_model); end
        t1 = $time;
        @(negedge clk);
        vectors++; if (gnt0_o !== 1'b1) begin miscompares++; $display("FAIL b2b_gnt_b: got %b want 1", gnt0_o); end
        req0_i = 1'b0;
        rd_model = ref_mem[y[7:2]];
        @(negedge clk);
        vectors++; if (ack0_o !== 1'b1 || rd_o !== rd_model) begin miscompares++; $display("FAIL b2b_ack_b: got ack=%b rd=%h want 1 %h", ack0_o, rd_o, rd_model); end
        vectors++; if (($time - t1) != 20) begin miscompares++; $display("FAIL b2b_spacing: got %0t want 20", $time - t1); end
        $display("txn back_to_back rd=%h spacing=%0t", rd_o, $time - t1);
    endtask

    task automatic test_abort();
        @(negedge clk);
        req1_i = 1'b1; we1_i = 1'b1; a1_i = 32'h1000_0008; wd1_i = 32'h1234_5678;
        @(negedge clk);
        vectors++; if (mem_we_o !== 1'b1) begin miscompares++; $display("FAIL abort_we_before: got %b want 1", mem_we_o); end
        #2 reset_n = 1'b0;
        #1;
        vectors++; if (mem_we_o !== 1'b0) begin miscompares++; $display("FAIL abort_we_async: got %b want 0", mem_we_o); end
        req1_i = 1'b0;
        last_model = 1; rd_model = 32'h0; err_model = 1'b0;
        @(negedge clk);
        vectors++; if ({ack1_o, ack0_o, gnt1_o, gnt0_o} !== 4'b0000) begin miscompares++; $display("FAIL abort_noack: got %b%b%b%b want 0000", ack1_o, ack0_o, gnt1_o, gnt0_o); end
        reset_n = 1'b1;
        @(negedge clk);
        vectors++; if ({ack1_o, gnt1_o, rd_o} !== 34'h0) begin miscompares++; $display("FAIL abort_idle: got ack=%b gnt=%b rd=%h want 0", ack1_o, gnt1_o, rd_o); end
        $display("txn abort reset during write, rd=%h", rd_o);
        // Aborted write must not have landed; the earlier DEADBEEF stays.
        run_pair(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h1000_0008, 32'h0, 32'h0);
    endtask

    task automatic test_random();
        logic [1:0] r;
        for (int n = 0; n < 40; n++) begin
            r = 2'($urandom_range(1, 3));
            run_pair(r[0], r[1], 1'($urandom), 1'($urandom), $urandom, $urandom, $urandom, $urandom);
        end
    endtask

    initial begin
        reset_n = 1'b0; fill = 1'b1;
        req0_i = 1'b0; req1_i = 1'b0; we0_i = 1'b0; we1_i = 1'b0;
        a0_i = '0; a1_i = '0; wd0_i = '0; wd1_i = '0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h2008_0004 + i;
        last_model = 1; rd_model = 32'h0; err_model = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        fill = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        test_read();
        test_write();
        test_misalign();
        test_continuous();
        test_back_to_back();
        test_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
